// File: rtl/grad_ctrl_pkg.sv
// Shared types and constants for the frame sequencer and its input FIFO.
package grad_ctrl_pkg;

  localparam int DATA_W = 24;

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Two entries hide the one-cycle read latency while the pipeline stalls.
  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/grad_skid_fifo.sv
// Small FIFO between frame-memory read data and the pipeline input stream.
// The head entry is presented as vld/data; the consumer pops on transfer.
module grad_skid_fifo
  import grad_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  pixel_t                i_push_data,
  input  logic                  i_pop,
  output logic [FIFO_CNT_W-1:0] o_count,
  output logic                  o_vld,
  output pixel_t                o_data
);

  pixel_t                mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic [FIFO_CNT_W-1:0] count;
  logic                  push_ok;
  logic                  pop_ok;

  assign pop_ok  = i_pop && (count != '0);
  assign push_ok = i_push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || pop_ok);

  // Storage, pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the storage is reset as well so the data output reads zero after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (push_ok) begin
        mem[wr_ptr] <= i_push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_count = count;
  assign o_vld   = (count != '0);
  assign o_data  = mem[rd_ptr];

endmodule

// File: rtl/grad_frame_ctrl.sv
// Frame sequencer: streams width*height pixels from frame memory into the
// colour-transform/gradient pipeline and writes its results to result memory.
module grad_frame_ctrl
  import grad_ctrl_pkg::*;
#(
  parameter int COL_W  = 10,
  parameter int ROW_W  = 10,
  parameter int ADDR_W = COL_W + ROW_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [COL_W-1:0]  i_width,
  input  logic [ROW_W-1:0]  i_height,
  output logic              o_ctrl_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  pixel_t            i_rd_data,
  output logic              o_rgb_vld,
  output pixel_t            o_rgb_data,
  input  logic              i_rgb_busy,
  input  logic              i_result_vld,
  input  pixel_t            i_result_data,
  output logic              o_result_busy,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output pixel_t            o_wr_data,
  input  logic              i_wr_busy
);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_W-1:0]     total;
  logic [ADDR_W-1:0]     frame_total;
  logic [ADDR_W-1:0]     rd_cnt;
  logic [ADDR_W-1:0]     res_cnt;
  logic [ADDR_W-1:0]     res_cnt_nxt;
  logic                  rd_inflight;
  logic                  rgb_pop;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W:0]   occupancy;
  logic                  rd_last;
  logic                  zero_frame;

  assign frame_total = ADDR_W'(i_width) * ADDR_W'(i_height);
  assign zero_frame  = (i_width == '0) || (i_height == '0);

  // Reads are throttled so FIFO entries plus the read in flight never exceed the depth.
  assign rgb_pop   = o_rgb_vld && !i_rgb_busy;
  assign occupancy = {1'b0, fifo_count} + (FIFO_CNT_W + 1)'(rd_inflight)
                   - (FIFO_CNT_W + 1)'(rgb_pop);
  assign o_rd_en   = (state == RUN) && (occupancy < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
  assign o_rd_addr = rd_cnt;
  assign rd_last   = (rd_cnt == total - ADDR_W'(1));

  // Results are only taken while a frame is active.
  assign o_result_busy = i_wr_busy;
  assign o_wr_en       = i_result_vld && !i_wr_busy && (state != IDLE);
  assign o_wr_addr     = res_cnt;
  assign o_wr_data     = i_result_data;
  assign res_cnt_nxt   = o_wr_en ? res_cnt + ADDR_W'(1) : res_cnt;

  assign o_ctrl_busy = (state != IDLE);
  assign o_done      = (state == DONE);

  grad_skid_fifo u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (rd_inflight),
    .i_push_data (i_rd_data),
    .i_pop       (rgb_pop),
    .o_count     (fifo_count),
    .o_vld       (o_rgb_vld),
    .o_data      (o_rgb_data)
  );

  // Next-state decode for the frame sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = zero_frame ? DONE : RUN;
      RUN:     if (o_rd_en && rd_last) state_nxt = DRAIN;
      DRAIN:   if (res_cnt_nxt == total) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, frame size, read/result counters and the read-in-flight flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      total       <= '0;
      rd_cnt      <= '0;
      res_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nxt;
      rd_inflight <= o_rd_en;
      case (state)
        IDLE: begin
          if (i_start) begin
            total   <= frame_total;
            rd_cnt  <= '0;
            res_cnt <= '0;
          end
        end
        DONE: begin
          rd_cnt  <= '0;
          res_cnt <= '0;
        end
        default: begin
          if (o_rd_en) rd_cnt <= rd_cnt + ADDR_W'(1);
          res_cnt <= res_cnt_nxt;
        end
      endcase
    end
  end

endmodule
